// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Iterative RV64M multiply/divide sequencer that sits beside the execute stage.
// A request is held on the REQ_* inputs until RESP_V pulses; meanwhile STALL
// freezes the execute stage. Multiplies are shift-add over operand magnitudes
// into a 128-bit product, divides are restoring shift-subtract; the sign fix-up
// and result selection happen in a dedicated FIX cycle. Divide-by-zero and
// signed overflow are resolved directly from IDLE (early out).
//
// Optional build macro:
//   MULDIV_FASTMUL_EN - when defined, multiplies use a single-cycle 128-bit
//                       combinational multiplier and complete as an early out;
//                       the iterative datapath then serves divides only.
//
// Ports:
//   clk          in   clock, rising edge
//   RESET        in   asynchronous active-low reset
//   REQ_V        in   request valid, held with stable operands until RESP_V
//   REQ_FUNC3    in   M-extension funct3 (MUL..REMU)
//   REQ_WORD     in   1 = 32-bit W variant
//   REQ_A/REQ_B  in   rs1 / rs2 operands
//   FLUSH        in   abort the in-flight operation
//   BUSY         out  state is not IDLE
//   STALL        out  REQ_V & ~RESP_V & ~FLUSH (combinational)
//   RESP_V       out  one-cycle result-valid pulse
//   RESP_RESULT  out  result, held until the next RESP_V
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            REQ_V,
    input  logic [2:0]      REQ_FUNC3,
    input  logic            REQ_WORD,
    input  logic [XLEN-1:0] REQ_A,
    input  logic [XLEN-1:0] REQ_B,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            STALL,
    output logic            RESP_V,
    output logic [XLEN-1:0] RESP_RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t       r_state;
    logic [5:0]   r_cnt;
    logic         r_resp_v;
    logic [63:0]  r_result;

    // Datapath state (no reset needed: always loaded at accept)
    logic [127:0] r_acc;      // product, or {remainder, quotient/dividend}
    logic [127:0] r_mcand;    // shifting multiplicand, or divisor in [63:0]
    logic [63:0]  r_mplier;   // shifting multiplier
    logic         r_neg_a;
    logic         r_neg_b;
    logic [2:0]   r_f3;
    logic         r_word;
    logic         r_is_div;

    // ---------------------------------------------------------------------
    // Helper functions
    // ---------------------------------------------------------------------
    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // Sign-correct a magnitude product and pick the requested half
    function automatic logic [63:0] mul_select(input logic [127:0] prod_mag,
                                               input logic         neg,
                                               input logic [2:0]   f3,
                                               input logic         word);
        logic [127:0] p;
        p = neg ? (~prod_mag + 128'd1) : prod_mag;
        if (word)
            return sext32(p[31:0]);
        else if (f3 == 3'd0)
            return p[63:0];
        else
            return p[127:64];
    endfunction

    // Sign-correct quotient/remainder magnitudes and pick one
    function automatic logic [63:0] div_select(input logic [63:0] q_mag,
                                               input logic [63:0] r_mag,
                                               input logic        neg_q,
                                               input logic        neg_r,
                                               input logic        rem_sel,
                                               input logic        word);
        logic [63:0] res;
        if (rem_sel)
            res = neg_r ? neg64(r_mag) : r_mag;
        else
            res = neg_q ? neg64(q_mag) : q_mag;
        return word ? sext32(res[31:0]) : res;
    endfunction

    // ---------------------------------------------------------------------
    // Operand preparation (evaluated in IDLE on the live request)
    // ---------------------------------------------------------------------
    logic        w_sgn_a_op;
    logic        w_sgn_b_op;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [63:0] w_a_mag;
    logic [63:0] w_b_mag;
    logic        w_is_div;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_early;
    logic [63:0] w_dividend_res;
    logic [63:0] w_early_res;
    logic        w_accept;

    always_comb begin
        w_sgn_a_op = 1'b0;
        w_sgn_b_op = 1'b0;
        case (REQ_FUNC3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                w_sgn_a_op = 1'b1;
                w_sgn_b_op = 1'b1;
            end
            3'd2:    w_sgn_a_op = 1'b1;   // MULHSU: only rs1 is signed
            default: ;
        endcase
    end

    assign w_a_ext = REQ_WORD ? (w_sgn_a_op ? sext32(REQ_A[31:0]) : {32'd0, REQ_A[31:0]}) : REQ_A;
    assign w_b_ext = REQ_WORD ? (w_sgn_b_op ? sext32(REQ_B[31:0]) : {32'd0, REQ_B[31:0]}) : REQ_B;
    assign w_neg_a = w_sgn_a_op & w_a_ext[63];
    assign w_neg_b = w_sgn_b_op & w_b_ext[63];
    assign w_a_mag = w_neg_a ? neg64(w_a_ext) : w_a_ext;
    assign w_b_mag = w_neg_b ? neg64(w_b_ext) : w_b_ext;

    assign w_is_div   = REQ_FUNC3[2];
    assign w_div_zero = w_is_div & (w_b_ext == 64'd0);
    // Only DIV/REM (funct3 4/6) are signed; overflow is min / -1
    assign w_div_ovf  = w_is_div & ~REQ_FUNC3[0] &
                        (REQ_WORD ? (REQ_A[31:0] == 32'h8000_0000 && REQ_B[31:0] == 32'hFFFF_FFFF)
                                  : (REQ_A == 64'h8000_0000_0000_0000 && REQ_B == 64'hFFFF_FFFF_FFFF_FFFF));
    // Special-case results always report the dividend sign-extended for W ops
    assign w_dividend_res = REQ_WORD ? sext32(REQ_A[31:0]) : REQ_A;

`ifdef MULDIV_FASTMUL_EN
    logic [127:0] w_fast_prod;
    assign w_fast_prod = {64'd0, w_a_mag} * {64'd0, w_b_mag};
    assign w_early     = w_div_zero | w_div_ovf | ~w_is_div;
`else
    assign w_early     = w_div_zero | w_div_ovf;
`endif

    always_comb begin
        w_early_res = 64'd0;
        if (w_div_zero)
            w_early_res = REQ_FUNC3[1] ? w_dividend_res : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (w_div_ovf)
            w_early_res = REQ_FUNC3[1] ? 64'd0 : w_dividend_res;
`ifdef MULDIV_FASTMUL_EN
        else
            w_early_res = mul_select(w_fast_prod, w_neg_a ^ w_neg_b, REQ_FUNC3, REQ_WORD);
`endif
    end

    assign w_accept = (r_state == S_IDLE) & REQ_V & ~FLUSH;

    // ---------------------------------------------------------------------
    // Iteration datapath
    // ---------------------------------------------------------------------
    logic [64:0] w_rem_sh;
    logic [64:0] w_diff;
    logic        w_sub_ok;
    logic        w_last;
    logic [63:0] w_fix_res;

    // Restoring step: shift the next dividend bit into the partial remainder
    assign w_rem_sh = {r_acc[127:64], r_acc[63]};
    assign w_diff   = w_rem_sh - {1'b0, r_mcand[63:0]};
    assign w_sub_ok = ~w_diff[64];
    assign w_last   = (r_cnt == (r_word ? 6'd31 : 6'd63));

    assign w_fix_res = r_is_div
        ? div_select(r_acc[63:0], r_acc[127:64], r_neg_a ^ r_neg_b, r_neg_a, r_f3[1], r_word)
        : mul_select(r_acc, r_neg_a ^ r_neg_b, r_f3, r_word);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_f3     <= REQ_FUNC3;
            r_word   <= REQ_WORD;
            r_is_div <= w_is_div;
            r_mplier <= w_b_mag;
            if (w_is_div) begin
                // W dividends are left-aligned so 32 steps consume them fully
                r_acc   <= {64'd0, (REQ_WORD ? {w_a_mag[31:0], 32'd0} : w_a_mag)};
                r_mcand <= {64'd0, w_b_mag};
            end else begin
                r_acc   <= 128'd0;
                r_mcand <= {64'd0, w_a_mag};
            end
        end else if (r_state == S_CALC) begin
            if (r_is_div) begin
                r_acc <= {(w_sub_ok ? w_diff[63:0] : w_rem_sh[63:0]), r_acc[62:0], w_sub_ok};
            end else begin
                if (r_mplier[0])
                    r_acc <= r_acc + r_mcand;
                r_mcand  <= {r_mcand[126:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[63:1]};
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_resp_v <= 1'b0;
            r_result <= 64'd0;
        end else begin
            r_resp_v <= 1'b0;
            if (FLUSH) begin
                r_state <= S_IDLE;
                r_cnt   <= 6'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (REQ_V) begin
                            if (w_early) begin
                                r_state  <= S_DONE;
                                r_resp_v <= 1'b1;
                                r_result <= w_early_res;
                            end else begin
                                r_state <= S_CALC;
                                r_cnt   <= 6'd0;
                            end
                        end
                    end
                    S_CALC: begin
                        if (w_last) begin
                            r_state <= S_FIX;
                            r_cnt   <= 6'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    S_FIX: begin
                        r_state  <= S_DONE;
                        r_resp_v <= 1'b1;
                        r_result <= w_fix_res;
                    end
                    default: r_state <= S_IDLE;   // S_DONE
                endcase
            end
        end
    end

    assign BUSY        = (r_state != S_IDLE);
    assign STALL       = REQ_V & ~r_resp_v & ~FLUSH;
    assign RESP_V      = r_resp_v;
    assign RESP_RESULT = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq: table-driven directed vectors for muldiv_seq plus hand-written
// sequences for reset mid-operation and flush.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk;
    logic        RESET;
    logic        REQ_V;
    logic [2:0]  REQ_FUNC3;
    logic        REQ_WORD;
    logic [63:0] REQ_A;
    logic [63:0] REQ_B;
    logic        FLUSH;
    logic        BUSY;
    logic        STALL;
    logic        RESP_V;
    logic [63:0] RESP_RESULT;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_seq #(.XLEN(64)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .REQ_V       (REQ_V),
        .REQ_FUNC3   (REQ_FUNC3),
        .REQ_WORD    (REQ_WORD),
        .REQ_A       (REQ_A),
        .REQ_B       (REQ_B),
        .FLUSH       (FLUSH),
        .BUSY        (BUSY),
        .STALL       (STALL),
        .RESP_V      (RESP_V),
        .RESP_RESULT (RESP_RESULT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        early;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [2:0] f3, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp,
                           input logic early, input string name);
        vec_t v;
        v.f3 = f3; v.w = w; v.a = a; v.b = b; v.exp = exp; v.early = early; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [2:0] f3, input logic w, input logic early);
        if (early) return 1;
`ifdef MULDIV_FASTMUL_EN
        if (!f3[2]) return 1;
`endif
        return w ? 34 : 66;
    endfunction

    // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 of the cycle after DONE.
    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat,
                          input string name);
        int   cyc;
        logic got;
        logic hs_bad;
        REQ_V = 1'b1; REQ_FUNC3 = f3; REQ_WORD = w; REQ_A = a; REQ_B = b;
        #1;
        cyc = 0; got = 1'b0; hs_bad = 1'b0;
        while (!got && cyc < 200) begin
            if (RESP_V === 1'b1) begin
                got = 1'b1;
            end else begin
                if (STALL !== 1'b1 || BUSY !== (cyc != 0)) hs_bad = 1'b1;
                @(posedge clk); #2;
                cyc++;
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s latency: no RESP_V within %0d cycles, expected cycle %0d", name, cyc, lat);
        end else if (cyc != lat) begin
            n_fail++;
            $display("FAIL %s latency: RESP_V in cycle %0d expected cycle %0d", name, cyc, lat);
        end
        check64({name, " result"}, RESP_RESULT, exp);
        check64({name, " stall/busy"}, {62'd0, hs_bad, STALL}, 64'd0);
        REQ_V = 1'b0;
        @(posedge clk); #1;
        check64({name, " pulse"}, {63'd0, RESP_V}, 64'd0);
    endtask

    initial begin
        RESET = 1'b0; REQ_V = 1'b0; REQ_FUNC3 = 3'd0; REQ_WORD = 1'b0;
        REQ_A = 64'd0; REQ_B = 64'd0; FLUSH = 1'b0;

        add_vec(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "MUL -3*7");
        add_vec(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "MULH -3*7");
        add_vec(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "MULHU ones");
        add_vec(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'd1, 1'b0, "MULH -2*min");
        add_vec(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "MULHSU");
        add_vec(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, "MULHU 2^63");
        add_vec(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "DIV -20/6");
        add_vec(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "REM -20/6");
        add_vec(3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0, "DIVU big");
        add_vec(3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "DIVU /0");
        add_vec(3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1, "REMU /0");
        add_vec(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, "DIV ovf");
        add_vec(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, "REM ovf");
        add_vec(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, "DIVW ovf");
        add_vec(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b0, "DIVUW");
        add_vec(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "DIVUW sext");
        add_vec(3'd0, 1'b1, 64'h0000_0000_0001_0000, 64'h8000, 64'hFFFF_FFFF_8000_0000, 1'b0, "MULW");
        add_vec(3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "DIVW -7/2");
        add_vec(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "REMW -7/2");
        add_vec(3'd7, 1'b1, 64'h0000_0000_8000_0000, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 1'b1, "REMUW /0");

        // Reset state
        #12;
        check64("reset BUSY", {63'd0, BUSY}, 64'd0);
        check64("reset RESP_V", {63'd0, RESP_V}, 64'd0);
        check64("reset RESP_RESULT", RESP_RESULT, 64'd0);
        check64("reset STALL", {63'd0, STALL}, 64'd0);
        @(posedge clk); #1;
        RESET = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp,
                   exp_latency(vecs[i].f3, vecs[i].w, vecs[i].early), vecs[i].name);

        // Reset mid-CALC of a DIV (RESP_RESULT holds a nonzero value beforehand)
        REQ_V = 1'b1; REQ_FUNC3 = 3'd4; REQ_WORD = 1'b0;
        REQ_A = 64'hFFFF_FFFF_FFFF_FFEC; REQ_B = 64'd6;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        check64("midcalc BUSY before reset", {63'd0, BUSY}, 64'd1);
        RESET = 1'b0;
        #1;
        check64("async reset BUSY", {63'd0, BUSY}, 64'd0);
        check64("async reset RESP_V", {63'd0, RESP_V}, 64'd0);
        check64("async reset RESP_RESULT", RESP_RESULT, 64'd0);
        REQ_V = 1'b0;
        @(posedge clk); #1;
        RESET = 1'b1;
        @(posedge clk); #1;
        check64("post reset idle BUSY", {63'd0, BUSY}, 64'd0);
        run_op(3'd5, 1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "post reset DIVU /0");

        // FLUSH at cycle 10 of a DIV, then a MUL in cycle 12
        REQ_V = 1'b1; REQ_FUNC3 = 3'd4; REQ_WORD = 1'b0;
        REQ_A = 64'hFFFF_FFFF_FFFF_FFEC; REQ_B = 64'd6;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        FLUSH = 1'b1;
        #1;
        check64("flush STALL", {63'd0, STALL}, 64'd0);
        @(posedge clk); #1;
        FLUSH = 1'b0; REQ_V = 1'b0;
        check64("flush BUSY k+1", {63'd0, BUSY}, 64'd0);
        check64("flush RESP_V k+1", {63'd0, RESP_V}, 64'd0);
        @(posedge clk); #1;
        check64("flush RESP_V k+2", {63'd0, RESP_V}, 64'd0);
        run_op(3'd0, 1'b0, 64'd3, 64'd4, 64'd12, exp_latency(3'd0, 1'b0, 1'b0), "MUL after flush");

        // Back-to-back: a second request in the IDLE cycle right after DONE
        run_op(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66, "REMU back-to-back");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV64M multiply/divide sequencer beside the execute stage. It takes M-extension operations (opcode 0110011/0111011 with funct7 0000001) off the single-cycle ALU path and computes them over multiple cycles. It stalls the execute stage until the result is ready, then returns a 64-bit result for the stage to latch into MEM_ALU_RESULT.

## Interface
- XLEN, 64, operand/result width; only 64 is supported.
- clk  in  1  clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ_V  in  1  request valid; must stay high with stable operands until RESP_V.
- REQ_FUNC3  in  3  M-extension funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- REQ_WORD  in  1  1 = W variant (opcode 0111011); only funct3 0, 4, 5, 6, 7 are legal.
- REQ_A, REQ_B  in  64  operands rs1, rs2.
- FLUSH  in  1  abort the in-flight operation.
- BUSY  out  1  high when state is not IDLE.
- STALL  out  1  combinational: REQ_V & ~RESP_V & ~FLUSH.
- RESP_V  out  1  one-cycle result-valid pulse.
- RESP_RESULT  out  64  result; holds its value until the next RESP_V.

## Operation
- States:
  - IDLE: waits for REQ_V.
  - CALC: one iteration per cycle; iteration counter counts 0 to N-1.
  - FIX: sign correction and result selection.
  - DONE: drives RESP_V.
- Iteration count N: 64 for 64-bit operations, 32 for W operations.
- Transitions:
  - IDLE→CALC when REQ_V is high, no special case applies, and FLUSH is low.
  - CALC→FIX after iteration N-1.
  - FIX→DONE.
  - DONE→IDLE unconditionally.
  - FLUSH from any state: next state IDLE, RESP_V stays low. FLUSH has priority over accepting a request.
- Operand preparation, captured at accept:
  - W ops: use bits [31:0] of each operand; sign-extend for signed ops, zero-extend for unsigned ops.
  - Signed operands are converted to magnitudes; operand signs are recorded.
  - MULHSU treats only A as signed.
- Multiply: shift-add over magnitudes into a 128-bit product. In FIX, negate the product if the signs differ.
  - MUL returns prod[63:0].
  - MULH, MULHSU and MULHU return prod[127:64].
  - MULW returns prod[31:0] sign-extended.
- Divide: restoring shift-subtract over magnitudes.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Special cases, detected in IDLE; go straight IDLE→DONE (early out):
  - Divide by zero (B, or B[31:0] for W, equals 0): quotient is all ones; remainder is the dividend.
  - Signed overflow (most-negative value / -1): quotient is the dividend; remainder is 0.
- All W results, including DIVUW and REMUW, are sign-extended from bit 31.
- Back-to-back: if REQ_V is high in IDLE the cycle after DONE, it is a new request.

## Timing
- Reset values: state IDLE, BUSY 0, RESP_V 0, RESP_RESULT 0, counter 0. Reset takes effect immediately and asynchronously, including mid-CALC.
- Accept cycle = cycle 0.
- Normal ops:
  - CALC occupies cycles 1..N.
  - FIX is cycle N+1.
  - RESP_V is high in cycle N+2: cycle 66 for 64-bit ops, cycle 34 for W ops.
- Early out: RESP_V is high in cycle 1.
- The execute stage advances on the edge that ends the DONE cycle, because STALL is low in that cycle.
- FLUSH in cycle k: BUSY is 0 in cycle k+1. No RESP_V is produced for the aborted operation.
- FLUSH has no effect in IDLE when REQ_V is low.

## Configuration
- MULDIV_FASTMUL_EN:
  - Defined: every multiply uses a single-cycle combinational 128-bit multiplier. Multiplies go IDLE→DONE with RESP_V in cycle 1; the CALC datapath serves divides only.
  - Undefined: multiplies are iterative (latency N+2).
  - Divide behaviour is identical in both builds.

## Test plan
- Reset mid-CALC: drive RESET low at cycle 10 of a DIV → BUSY, RESP_V and RESP_RESULT are 0 in the same cycle. After release, the state is IDLE.
- MUL with A = 0xFFFFFFFFFFFFFFFD (-3), B = 7 → RESP_RESULT = 0xFFFFFFFFFFFFFFEB. RESP_V in cycle 66, or cycle 1 with MULDIV_FASTMUL_EN. MULHU with A = B = 0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE.
- DIV with A = -20, B = 6 → 0xFFFFFFFFFFFFFFFD in cycle 66. REM with the same operands → 0xFFFFFFFFFFFFFFFE. STALL is high in cycles 0–65 and low in cycle 66.
- DIVU with A = 5, B = 0 → 0xFFFFFFFFFFFFFFFF in cycle 1. REMU with the same operands → 5. DIV with A = 0x8000000000000000, B = -1 → 0x8000000000000000; REM with the same operands → 0.
- W ops:
  - DIVW with A[31:0] = 0x80000000, B[31:0] = 0xFFFFFFFF → 0xFFFFFFFF80000000 in cycle 1.
  - DIVUW with A = 0x00000000FFFFFFFE, B = 2 → 0x000000007FFFFFFF in cycle 34.
  - MULW with A = 0x10000, B = 0x8000 → 0xFFFFFFFF80000000.
- FLUSH at cycle 10 of a DIV → BUSY is 0 in cycle 11 and RESP_V never pulses. Then issue MUL with A = 3, B = 4 in cycle 12 → RESP_RESULT = 12.
